dac_slew: RTL and testbench

Slew-rate limiter and output formatter between `pdh_core` and the DAC pins. It captures the packed two-channel DAC word on each `dac_wrt_o` pulse from `pdh_core` and moves each channel's output toward its new target in bounded steps on a programmable tick. It converts the signed codes to offset binary for the converter. This keeps PS-commanded setpoint jumps from kicking the laser/piezo actuators.

---
 rtl/dac_slew_pkg.sv | 11 +
 rtl/dac_slew_chan.sv | 49 ++++
 rtl/dac_slew.sv | 39 +++
 tb/tb_dac_slew.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dac_slew_pkg.sv
// pdh_dac_pkg: shared DAC word layout and code-format helpers
package pdh_dac_pkg;
  localparam int DAC_W = 14;
  localparam logic [DAC_W-1:0] DAC_MID = 14'h2000;
  function automatic logic [DAC_W-1:0] to_offset_bin(input logic [DAC_W-1:0] code);
    return {~code[DAC_W-1], code[DAC_W-2:0]};
  endfunction
  function automatic logic [2*DAC_W-1:0] pack_dac(input logic [DAC_W-1:0] b, input logic [DAC_W-1:0] a);
    return {b, a};
  endfunction
endpackage

// File: rtl/dac_slew_chan.sv
// dac_slew_chan: per-channel target/current registers, bounded stepping and offset-binary output
module dac_slew_chan
  import pdh_dac_pkg::*;
#(
  parameter int DW = DAC_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] tgt_in,
  input  logic          tick,
  input  logic [DW-1:0] step,
  output logic [DW-1:0] dac_o,
  output logic          changed_o,
  output logic          at_target_o
);
  logic signed [DW-1:0] r_tgt, r_cur;
  logic signed [DW:0]   w_d;
  logic [DW:0]          w_mag;
  logic [DW-1:0]        w_next, w_fmt;
  // signed distance to target, its magnitude, and the next current value
  always_comb begin
    w_d    = {r_tgt[DW-1], r_tgt} - {r_cur[DW-1], r_cur};
    w_mag  = w_d[DW] ? -w_d : w_d;
    w_next = (step == '0 || w_mag <= {1'b0, step}) ? r_tgt : (w_d[DW] ? r_cur - step : r_cur + step);
    w_fmt  = to_offset_bin(r_cur);
  end
  // target capture and current update; zero step bypasses the tick
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tgt <= '0;
      r_cur <= '0;
    end else begin
      r_tgt <= load ? tgt_in : r_tgt;
      r_cur <= (step == '0 || tick) ? w_next : r_cur;
    end
  end
  // registered output code with a change flag aligned to it
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_o     <= DAC_MID;
      changed_o <= 1'b0;
    end else begin
      dac_o     <= w_fmt;
      changed_o <= w_fmt != dac_o;
    end
  end
  assign at_target_o = r_cur == r_tgt;
endmodule

// File: rtl/dac_slew.sv
// dac_slew: two-channel slew-rate limiter and offset-binary formatter feeding the DAC pins
module dac_slew
  import pdh_dac_pkg::*;
#(
  parameter int DW    = DAC_W,
  parameter int DIV_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*DW-1:0] dac_dat_i,
  input  logic            dac_wrt_i,
  input  logic [DW-1:0]   step_i,
  input  logic [DIV_W-1:0] div_i,
  output logic [DW-1:0]   dac_a_o,
  output logic [DW-1:0]   dac_b_o,
  output logic            dac_valid_o,
  output logic            busy_o,
  output logic [1:0]      at_target_o
);
  logic [DIV_W-1:0] r_cnt;
  logic             w_tick, w_chg_a, w_chg_b, w_at_a, w_at_b;
  assign w_tick = r_cnt >= div_i;
  // free-running tick divider; >= lets a shrinking div_i apply at once
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
  end
  dac_slew_chan #(.DW(DW)) u_a (
    .clk(clk), .rst(rst), .load(dac_wrt_i), .tgt_in(dac_dat_i[DW-1:0]), .tick(w_tick),
    .step(step_i), .dac_o(dac_a_o), .changed_o(w_chg_a), .at_target_o(w_at_a)
  );
  dac_slew_chan #(.DW(DW)) u_b (
    .clk(clk), .rst(rst), .load(dac_wrt_i), .tgt_in(dac_dat_i[2*DW-1:DW]), .tick(w_tick),
    .step(step_i), .dac_o(dac_b_o), .changed_o(w_chg_b), .at_target_o(w_at_b)
  );
  assign dac_valid_o = w_chg_a | w_chg_b;
  assign at_target_o = {w_at_b, w_at_a};
  assign busy_o      = ~&at_target_o;
endmodule

// File: tb/tb_dac_slew.sv
// tb_dac_slew: randomized and directed checks of dac_slew against a behavioural model
module tb_dac_slew;
  import pdh_dac_pkg::*;
  logic        clk = 0, rst = 1, dac_wrt_i = 0, dac_valid_o, busy_o;
  logic [27:0] dac_dat_i = '0;
  logic [13:0] step_i = '0, dac_a_o, dac_b_o;
  logic [15:0] div_i = '0;
  logic [1:0]  at_target_o;
  int n_tests = 0, n_fail = 0;
  bit chk_on = 0;
  int m_tgt[2] = '{0, 0}, m_cur[2] = '{0, 0}, m_out[2] = '{8192, 8192};
  int m_cnt = 0;
  bit m_valid = 0;

  dac_slew dut (
    .clk(clk), .rst(rst), .dac_dat_i(dac_dat_i), .dac_wrt_i(dac_wrt_i), .step_i(step_i),
    .div_i(div_i), .dac_a_o(dac_a_o), .dac_b_o(dac_b_o), .dac_valid_o(dac_valid_o),
    .busy_o(busy_o), .at_target_o(at_target_o)
  );

  always #5 clk = ~clk;

  function automatic int fmt(input int c);
    return (c + 8192) & 16383;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_tgt = '{0, 0}; m_cur = '{0, 0}; m_out = '{8192, 8192}; m_cnt = 0; m_valid = 0;
    end else begin
      bit tick;
      int s;
      m_valid = 0;
      for (int c = 0; c < 2; c++) begin
        if (fmt(m_cur[c]) != m_out[c]) m_valid = 1;
        m_out[c] = fmt(m_cur[c]);
      end
      tick = m_cnt >= int'(div_i);
      s = int'(step_i);
      for (int c = 0; c < 2; c++) begin
        int d;
        d = m_tgt[c] - m_cur[c];
        if (s == 0) m_cur[c] = m_tgt[c];
        else if (tick) m_cur[c] = (d > s) ? m_cur[c] + s : (d < -s) ? m_cur[c] - s : m_tgt[c];
      end
      if (dac_wrt_i) begin
        m_tgt[0] = int'($signed(dac_dat_i[13:0]));
        m_tgt[1] = int'($signed(dac_dat_i[27:14]));
      end
      m_cnt = tick ? 0 : m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_a", int'(dac_a_o), m_out[0]);
      check("model_b", int'(dac_b_o), m_out[1]);
      check("model_valid", int'(dac_valid_o), int'(m_valid));
      check("model_busy", int'(busy_o), int'(m_tgt[0] != m_cur[0] || m_tgt[1] != m_cur[1]));
      check("model_at", int'(at_target_o), {m_tgt[1] == m_cur[1], m_tgt[0] == m_cur[0]});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] b, input logic [13:0] a);
    dac_dat_i = pack_dac(b, a);
    dac_wrt_i = 1;
    cyc(1);
    dac_wrt_i = 0;
  endtask

  initial begin
    int n;
    cyc(2);
    chk_on = 1;
    cyc(3);
    check("rst_a", int'(dac_a_o), 'h2000);
    check("rst_b", int'(dac_b_o), 'h2000);
    check("rst_busy", int'(busy_o), 0);
    check("rst_at", int'(at_target_o), 3);
    check("rst_valid", int'(dac_valid_o), 0);
    rst = 0;
    cyc(2);
    step_i = 0;
    wr(14'd0, 14'h0123);
    cyc(1);
    check("byp_early", int'(dac_a_o), 'h2000);
    cyc(1);
    check("byp_a", int'(dac_a_o), 'h2123);
    check("byp_valid", int'(dac_valid_o), 1);
    check("byp_model", m_out[0], 'h2123);
    cyc(1);
    check("byp_pulse_end", int'(dac_valid_o), 0);
    wr(14'd0, 14'd0);
    cyc(3);
    step_i = 100; div_i = 0;
    wr(14'd0, 14'd291);
    check("ramp_busy", int'(busy_o), 1);
    cyc(2);
    check("ramp_100", int'(dac_a_o), 'h2064);
    cyc(1);
    check("ramp_200", int'(dac_a_o), 'h20C8);
    check("ramp_busy_drop", int'(busy_o), 0);
    cyc(1);
    check("ramp_291", int'(dac_a_o), 'h2123);
    step_i = 14'h1000; div_i = 3;
    wr(14'h2000, 14'd291);
    n = 0;
    while (dac_b_o != 14'h1000 && n < 40) begin cyc(1); n++; end
    check("neg_mid", int'(dac_b_o), 'h1000);
    check("neg_model", m_out[1], 'h1000);
    n = 0;
    while (dac_b_o != 14'h0000 && n < 20) begin cyc(1); n++; end
    check("neg_end", int'(dac_b_o), 0);
    check("neg_spacing", n, 4);
    step_i = 0; div_i = 0;
    wr(14'h2000, 14'd0);
    cyc(3);
    step_i = 10;
    wr(14'h2000, 14'd1000);
    cyc(4);
    wr(14'h2000, 14'd20);
    cyc(1);
    check("rt_50", int'(dac_a_o), 'h2032);
    cyc(1);
    check("rt_40", int'(dac_a_o), 'h2028);
    cyc(1);
    check("rt_30", int'(dac_a_o), 'h201E);
    cyc(1);
    check("rt_20", int'(dac_a_o), 'h2014);
    cyc(3);
    check("rt_hold", int'(dac_a_o), 'h2014);
    check("rt_idle", int'(busy_o), 0);
    step_i = 1;
    wr(14'h2000, 14'h1FFF);
    cyc(20);
    rst = 1;
    cyc(1);
    check("rr_a", int'(dac_a_o), 'h2000);
    check("rr_b", int'(dac_b_o), 'h2000);
    rst = 0;
    cyc(10);
    check("rr_still", int'(dac_a_o), 'h2000);
    check("rr_at", int'(at_target_o), 3);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: step_i = 0;
        1: step_i = 14'($urandom_range(1, 20));
        2: step_i = 14'($urandom_range(1, 16383));
        default: step_i = 14'h1000;
      endcase
      div_i = 16'($urandom_range(0, 3));
      dac_wrt_i = $urandom_range(0, 7) == 0;
      dac_dat_i = 28'($urandom);
      rst = $urandom_range(0, 249) == 0;
      cyc($urandom_range(1, 6));
    end
    dac_wrt_i = 0; rst = 0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
